// File: rtl/pwm_rs_ctrl.sv
// PWM controller that drives a downstream RS flip-flop with one-cycle set/reset pulses.
// Duty and period changes are staged and applied only at period boundaries.
module pwm_rs_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [WIDTH-1:0] Period,
  input  logic [WIDTH-1:0] Duty_In,
  input  logic             Duty_Valid,
  output logic             Duty_Ready,
  output logic             S,
  output logic             R,
  output logic             PWM_Q,
  output logic             Period_End
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] per_act;
  logic [WIDTH-1:0] duty_pend;
  logic             full;
  logic             pwm_q;
  logic             load;
  logic             accept;

  assign Duty_Ready = ~full;
  assign accept     = Duty_Valid & ~full;
  assign PWM_Q      = pwm_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load       = 1'b0;
    S          = 1'b0;
    R          = 1'b0;
    Period_End = 1'b0;

    case (state)
      IDLE: begin
        // Leaving RUN with the output high needs one trailing reset pulse.
        R = pwm_q;
        if (En) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
      end

      RUN: begin
        S          = (cnt == '0) && (duty_act != '0);
        R          = (cnt == duty_act) && (duty_act <= per_act);
        Period_End = (cnt == per_act);
        if (!En) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == per_act) begin
          cnt_nxt = '0;
          load    = 1'b1;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      duty_act  <= '0;
      per_act   <= '0;
      duty_pend <= '0;
      full      <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      if (load) begin
        per_act <= Period;
        if (full) duty_act <= duty_pend;
      end

      // A load empties the slot; a new request is only taken when it was
      // already empty, so the two never collide.
      if (load && full) begin
        full <= 1'b0;
      end else if (accept) begin
        full      <= 1'b1;
        duty_pend <= Duty_In;
      end

      if (S)      pwm_q <= 1'b1;
      else if (R) pwm_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_rs_ctrl.sv
// Directed bench for pwm_rs_ctrl: WIDTH=8, P=9, hand-derived per-cycle S/R/Q/Period_End/Duty_Ready.
module tb_pwm_rs_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       En;
  logic [7:0] Period;
  logic [7:0] Duty_In;
  logic       Duty_Valid;
  logic       Duty_Ready;
  logic       S;
  logic       R;
  logic       PWM_Q;
  logic       Period_End;

  int vectors = 0;
  int errs    = 0;

  pwm_rs_ctrl #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .En        (En),
    .Period    (Period),
    .Duty_In   (Duty_In),
    .Duty_Valid(Duty_Valid),
    .Duty_Ready(Duty_Ready),
    .S         (S),
    .R         (R),
    .PWM_Q     (PWM_Q),
    .Period_End(Period_End)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Observed bundle is {S, R, PWM_Q, Period_End, Duty_Ready}.
  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed {S,R,Q,PE,RDY}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Expected outputs at count c of a period with duty d and P=9.
  // q0 is the output level during count 0 (left over from the previous period).
  task automatic check_cycle(input string tag, input int c, input int d,
                             input logic q0, input logic rdy);
    logic es, er, eq, epe;
    es  = (c == 0) && (d != 0);
    er  = (c == d) && (d <= 9);
    eq  = (c == 0) ? q0 : ((d != 0) && (c <= d));
    epe = (c == 9);
    check($sformatf("%s c%0d", tag, c), {S, R, PWM_Q, Period_End, Duty_Ready},
          {es, er, eq, epe, rdy});
  endtask

  // One full period; optionally offers a duty value during count push_at.
  task automatic run_period(input string tag, input int d, input logic q0,
                            input int push_at, input logic [7:0] push_val);
    for (int c = 0; c < 10; c++) begin
      check_cycle(tag, c, d, q0, (push_at < 0) || (c <= push_at));
      if (c == push_at) begin
        Duty_Valid = 1'b1;
        Duty_In    = push_val;
      end
      tick();
      Duty_Valid = 1'b0;
    end
  endtask

  initial begin
    Rst_n      = 1'b0;
    En         = 1'b0;
    Period     = 8'd9;
    Duty_In    = 8'd0;
    Duty_Valid = 1'b0;
    tick();
    tick();
    check("reset", {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b00001);

    // Stage D=3 while idle, then start.
    Rst_n      = 1'b1;
    Duty_In    = 8'd3;
    Duty_Valid = 1'b1;
    tick();
    Duty_Valid = 1'b0;
    check("idle_full", {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b00000);
    En = 1'b1;
    tick();

    run_period("d3_a", 3, 1'b0, -1, 8'd0);

    // Push 7 at count 4; a second push at 6 and one at the wrap edge are refused.
    for (int c = 0; c < 10; c++) begin
      check_cycle("d3_b", c, 3, 1'b0, c <= 4);
      if (c == 4) begin Duty_Valid = 1'b1; Duty_In = 8'd7; end
      if (c == 6) begin Duty_Valid = 1'b1; Duty_In = 8'd9; end
      if (c == 9) begin Duty_Valid = 1'b1; Duty_In = 8'd2; end
      tick();
      Duty_Valid = 1'b0;
    end

    run_period("d7", 7, 1'b0, 0, 8'd0);
    run_period("d0", 0, 1'b0, 0, 8'd10);
    run_period("d10_a", 10, 1'b0, -1, 8'd0);
    run_period("d10_b", 10, 1'b1, 0, 8'd5);

    // D=5 period entered with Q already high; drop En at count 2.
    check_cycle("d5_en", 0, 5, 1'b1, 1'b1);
    tick();
    check_cycle("d5_en", 1, 5, 1'b1, 1'b1);
    tick();
    check_cycle("d5_en", 2, 5, 1'b1, 1'b1);
    En = 1'b0;
    tick();
    check("en_drop_r", {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b01101);
    tick();
    check("en_drop_q0", {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_quiet%0d", i), {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b00001);
    end

    // Restart keeps D=5; reset at count 2 aborts without an R pulse.
    En = 1'b1;
    tick();
    check_cycle("d5_rst", 0, 5, 1'b0, 1'b1);
    tick();
    check_cycle("d5_rst", 1, 5, 1'b0, 1'b1);
    tick();
    check_cycle("d5_rst", 2, 5, 1'b0, 1'b1);
    Rst_n = 1'b0;
    tick();
    check("rst_mid", {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b00001);
    Rst_n = 1'b1;
    En    = 1'b0;
    tick();
    check("rst_idle", {S, R, PWM_Q, Period_End, Duty_Ready}, 5'b00001);

    // After reset with nothing staged the first period runs at duty 0.
    En = 1'b1;
    tick();
    run_period("post_rst_d0", 0, 1'b0, -1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
